// File: rtl/vcache_req_arbiter_pkg.sv
// Shared helpers for the vcache request arbiter slice.
// rr_next: modulo-n increment of an index. It is used for the round-robin
// scan start and for the ID FIFO pointer wrap, including non-power-of-two n.
package vcache_req_arbiter_pkg;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/vcache_arb_id_fifo.sv
// In-order ID FIFO. It records which requester owns each outstanding cache
// request, so that in-order responses can be routed back to that requester.
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   v_i, data_i        push request and pushed ID
//   ready_o            space available (not full)
//   v_o, data_o        head valid (not empty) and head ID
//   yumi_i             pop the head
//   full_o, empty_o    occupancy flags
module vcache_arb_id_fifo
  import vcache_req_arbiter_pkg::*;
#(
  parameter int width_p       = 2,
  parameter int els_p         = 4,
  parameter int count_width_p = $clog2(els_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_w_lp = $clog2(els_p);

  logic [width_p-1:0]       r_mem [els_p];
  logic [ptr_w_lp-1:0]      r_wptr;
  logic [ptr_w_lp-1:0]      r_rptr;
  logic [count_width_p-1:0] r_count;
  logic                     w_push;
  logic                     w_pop;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return ptr_w_lp'(rr_next(int'(p), els_p));
  endfunction

  assign full_o  = (r_count == count_width_p'(els_p));
  assign empty_o = (r_count == '0);
  assign ready_o = ~full_o;
  assign v_o     = ~empty_o;
  assign data_o  = r_mem[r_rptr];
  assign w_push  = v_i & ready_o;
  assign w_pop   = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + count_width_p'(1);
        2'b01:   r_count <= r_count - count_width_p'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The storage array holds data only, so reset does not touch it.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/vcache_req_arbiter.sv
// Shares one vcache request/response port among num_req_p requesters.
// Requests are arbitrated round-robin. Each winner's ID is queued in order,
// and in-order cache responses are steered back to the matching requester.
// The request and response paths add zero cycles of latency.
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   v_i, pkt_i, ready_o            per-requester request side
//   v_o, data_o, yumi_i            per-requester response side (data broadcast)
//   cache_v_o, cache_pkt_o,
//   cache_ready_i                  request port toward the cache
//   cache_v_i, cache_data_i,
//   cache_yumi_o                   response port from the cache
module vcache_req_arbiter
  import vcache_req_arbiter_pkg::*;
#(
  parameter int num_req_p    = 4,
  parameter int pkt_width_p  = 64,
  parameter int data_width_p = 32,
  parameter int max_out_p    = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p-1:0]             v_i,
  input  logic [num_req_p*pkt_width_p-1:0] pkt_i,
  output logic [num_req_p-1:0]             ready_o,
  output logic [num_req_p-1:0]             v_o,
  output logic [data_width_p-1:0]          data_o,
  input  logic [num_req_p-1:0]             yumi_i,
  output logic                             cache_v_o,
  output logic [pkt_width_p-1:0]           cache_pkt_o,
  input  logic                             cache_ready_i,
  input  logic                             cache_v_i,
  input  logic [data_width_p-1:0]          cache_data_i,
  output logic                             cache_yumi_o
);

  localparam int lg_num_req_lp = $clog2(num_req_p);
  localparam int lg_max_out_lp = $clog2(max_out_p + 1);

  logic [lg_num_req_lp-1:0] r_last;
  logic [num_req_p-1:0]     w_grant;
  logic [lg_num_req_lp-1:0] w_grant_idx;
  logic [lg_num_req_lp-1:0] w_head;
  logic                     w_issue;
  logic                     w_resp_v;
  logic                     w_fifo_ready;
  logic                     w_fifo_v;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;

  // Scan the requesters starting one past the last issued requester. The
  // first valid requester found wins.
  always_comb begin
    int idx;
    w_grant     = '0;
    w_grant_idx = '0;
    idx         = rr_next(int'(r_last), num_req_p);
    for (int k = 0; k < num_req_p; k++) begin
      if (v_i[idx] && (w_grant == '0)) begin
        w_grant[idx] = 1'b1;
        w_grant_idx  = lg_num_req_lp'(idx);
      end
      idx = rr_next(idx, num_req_p);
    end
  end

  // Push is blocked while full, even if the head pops in the same cycle.
  // This keeps yumi_i out of the ready path.
  assign cache_v_o   = ~reset_i & (|v_i) & ~w_fifo_full;
  assign ready_o     = w_grant & {num_req_p{~reset_i & cache_ready_i & ~w_fifo_full}};
  assign cache_pkt_o = pkt_i[w_grant_idx*pkt_width_p +: pkt_width_p];
  assign w_issue     = cache_v_o & cache_ready_i;

  assign w_resp_v     = ~reset_i & cache_v_i & ~w_fifo_empty;
  assign cache_yumi_o = w_resp_v & yumi_i[w_head];
  assign data_o       = cache_data_i;

  always_comb begin
    v_o         = '0;
    v_o[w_head] = w_resp_v;
  end

  // Priority moves only when a grant actually issues. While the cache
  // stalls, the grant therefore holds steady.
  always_ff @(posedge clk_i) begin
    if (reset_i)      r_last <= lg_num_req_lp'(num_req_p - 1);
    else if (w_issue) r_last <= w_grant_idx;
  end

  vcache_arb_id_fifo #(
    .width_p      (lg_num_req_lp),
    .els_p        (max_out_p),
    .count_width_p(lg_max_out_lp)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (w_issue),
    .data_i (w_grant_idx),
    .ready_o(w_fifo_ready),
    .v_o    (w_fifo_v),
    .data_o (w_head),
    .yumi_i (cache_yumi_o),
    .full_o (w_fifo_full),
    .empty_o(w_fifo_empty)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert ($onehot0(w_grant))
        else $error("arbiter grant is not one-hot");
      assert (!(cache_v_i && w_fifo_empty))
        else $error("cache response arrived with no outstanding request");
      assert ((yumi_i & ~v_o) == '0)
        else $error("yumi_i asserted without matching v_o");
      assert ((w_fifo_ready == ~w_fifo_full) && (w_fifo_v == ~w_fifo_empty))
        else $error("ID FIFO flags inconsistent");
    end
  end
`endif

endmodule
